// File: rtl/eth_tx_pkg.sv
// Shared types, framing constants and the byte-wide CRC-32 step for the GMII transmit MAC.
package eth_tx_pkg;

    // Each state names the kind of byte currently on gmii_txd.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_SFD,
        ST_DATA,
        ST_PAD,
        ST_FCS,
        ST_IFG
    } tx_state_e;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;

    function automatic logic [31:0] crc32_next_d8(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'd0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/crc32_d8.sv
// Byte-at-a-time CRC-32 (reflected 802.3) accumulator with synchronous re-init and enable.
module crc32_d8
    import eth_tx_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init_i,
    input  logic        en_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);

    logic [31:0] crc_q;

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= CRC_INIT;
        end else if (init_i) begin
            crc_q <= CRC_INIT;
        end else if (en_i) begin
            crc_q <= crc32_next_d8(crc_q, data_i);
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/gmii_tx_mac.sv
// GMII transmit framer: preamble, SFD, payload, zero pad, CRC-32 FCS and inter-frame gap.
module gmii_tx_mac
    import eth_tx_pkg::*;
#(
    parameter int MIN_DATA_LEN = 60,
    parameter int IFG_CYCLES   = 12,
    parameter int PREAMBLE_LEN = 7
) (
    input  logic       gmii_tx_clk,
    input  logic       rst_n,
    input  logic       tx_data_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_data_last,
    output logic       tx_data_ready,
    output logic       gmii_tx_en,
    output logic [7:0] gmii_txd,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err
);

    localparam logic [11:0] MIN_LEN = 12'(MIN_DATA_LEN);
    localparam logic [7:0]  PRE_LEN = 8'(PREAMBLE_LEN);
    localparam logic [7:0]  IFG_LEN = 8'(IFG_CYCLES);

    tx_state_e   state_q;
    logic [7:0]  cnt_q;
    logic [10:0] byte_cnt_q;
    logic        stomp_q;
    logic        ready_q;
    logic        en_q;
    logic [7:0]  txd_q;
    logic        busy_q;
    logic        done_q;
    logic        err_q;

    logic [31:0] crc;
    logic [31:0] fcs_word;
    logic [10:0] byte_cnt_inc;
    logic [1:0]  fcs_next_idx;
    logic        in_data;
    logic        accept;
    logic        underrun;
    logic        payload_end;
    logic        pad_emit;
    logic        frame_start;
    logic        crc_init;
    logic        crc_en;

    assign in_data      = (state_q == ST_SFD) || (state_q == ST_DATA);
    assign accept       = in_data && ready_q && tx_data_valid;
    assign underrun     = in_data && ready_q && !tx_data_valid;
    // Last payload byte on the wire (ready already dropped) or a pad byte on the wire.
    assign payload_end  = ((state_q == ST_DATA) && !ready_q) || (state_q == ST_PAD);
    assign pad_emit     = payload_end && ({1'b0, byte_cnt_q} < MIN_LEN);
    assign frame_start  = tx_data_valid &&
                          ((state_q == ST_IDLE) || ((state_q == ST_IFG) && (cnt_q >= IFG_LEN)));
    assign crc_init     = (state_q == ST_IDLE) || (state_q == ST_IFG);
    assign crc_en       = accept || pad_emit;
    assign byte_cnt_inc = (byte_cnt_q == 11'h7FF) ? byte_cnt_q : byte_cnt_q + 11'd1;
    assign fcs_word     = stomp_q ? crc : ~crc;
    assign fcs_next_idx = cnt_q[1:0] + 2'd1;

    crc32_d8 u_crc (
        .clk    (gmii_tx_clk),
        .rst_n  (rst_n),
        .init_i (crc_init),
        .en_i   (crc_en),
        .data_i (accept ? tx_data : 8'h00),
        .crc_o  (crc)
    );

    always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            byte_cnt_q <= '0;
            stomp_q    <= 1'b0;
            ready_q    <= 1'b0;
            en_q       <= 1'b0;
            txd_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (frame_start) begin
                state_q    <= ST_PREAMBLE;
                en_q       <= 1'b1;
                txd_q      <= PREAMBLE_BYTE;
                busy_q     <= 1'b1;
                cnt_q      <= 8'd1;
                byte_cnt_q <= '0;
                stomp_q    <= 1'b0;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        en_q  <= 1'b0;
                        txd_q <= '0;
                    end
                    ST_PREAMBLE: begin
                        if (cnt_q >= PRE_LEN) begin
                            state_q <= ST_SFD;
                            txd_q   <= SFD_BYTE;
                            ready_q <= 1'b1;
                        end else begin
                            txd_q <= PREAMBLE_BYTE;
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                    ST_SFD, ST_DATA, ST_PAD: begin
                        if (accept) begin
                            state_q    <= ST_DATA;
                            txd_q      <= tx_data;
                            byte_cnt_q <= byte_cnt_inc;
                            if (tx_data_last) ready_q <= 1'b0;
                        end else if (underrun) begin
                            // Stomped FCS is the raw CRC, i.e. the complement of the good FCS.
                            state_q <= ST_FCS;
                            txd_q   <= crc[7:0];
                            stomp_q <= 1'b1;
                            ready_q <= 1'b0;
                            cnt_q   <= '0;
                        end else if (pad_emit) begin
                            state_q    <= ST_PAD;
                            txd_q      <= 8'h00;
                            byte_cnt_q <= byte_cnt_inc;
                        end else begin
                            state_q <= ST_FCS;
                            txd_q   <= ~crc[7:0];
                            cnt_q   <= '0;
                        end
                    end
                    ST_FCS: begin
                        if (cnt_q[1:0] == 2'd3) begin
                            state_q <= ST_IFG;
                            en_q    <= 1'b0;
                            txd_q   <= 8'h00;
                            done_q  <= !stomp_q;
                            err_q   <= stomp_q;
                            cnt_q   <= 8'd1;
                        end else begin
                            txd_q <= fcs_word[{fcs_next_idx, 3'b000} +: 8];
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                    ST_IFG: begin
                        if (cnt_q >= IFG_LEN) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        en_q    <= 1'b0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign tx_data_ready = ready_q;
    assign gmii_tx_en    = en_q;
    assign gmii_txd      = txd_q;
    assign tx_busy       = busy_q;
    assign tx_done       = done_q;
    assign tx_err        = err_q;

endmodule

// File: tb/tb_gmii_tx_mac.sv
// Self-checking bench for gmii_tx_mac: a reference frame builder compares the full GMII byte stream.
module tb_gmii_tx_mac;

    localparam int IFG_N = 12;

    logic clk = 1'b0;
    always #4 clk = ~clk;

    logic       rst_n     = 1'b0;
    int         sel       = 0;
    logic       src_valid = 1'b0;
    logic       src_last  = 1'b0;
    logic [7:0] src_data  = 8'h00;

    logic       a_valid, a_last, a_ready, a_en, a_busy, a_done, a_err;
    logic [7:0] a_data, a_txd;
    logic       b_valid, b_last, b_ready, b_en, b_busy, b_done, b_err;
    logic [7:0] b_data, b_txd;

    assign a_valid = (sel == 0) && src_valid;
    assign a_last  = (sel == 0) && src_last;
    assign a_data  = (sel == 0) ? src_data : 8'h00;
    assign b_valid = (sel == 1) && src_valid;
    assign b_last  = (sel == 1) && src_last;
    assign b_data  = (sel == 1) ? src_data : 8'h00;

    gmii_tx_mac #(.MIN_DATA_LEN(0)) dut0 (
        .gmii_tx_clk(clk), .rst_n(rst_n),
        .tx_data_valid(a_valid), .tx_data(a_data), .tx_data_last(a_last), .tx_data_ready(a_ready),
        .gmii_tx_en(a_en), .gmii_txd(a_txd), .tx_busy(a_busy), .tx_done(a_done), .tx_err(a_err)
    );

    gmii_tx_mac dut1 (
        .gmii_tx_clk(clk), .rst_n(rst_n),
        .tx_data_valid(b_valid), .tx_data(b_data), .tx_data_last(b_last), .tx_data_ready(b_ready),
        .gmii_tx_en(b_en), .gmii_txd(b_txd), .tx_busy(b_busy), .tx_done(b_done), .tx_err(b_err)
    );

    logic       m_ready, m_en, m_busy, m_done, m_err;
    logic [7:0] m_txd;
    assign m_ready = (sel == 0) ? a_ready : b_ready;
    assign m_en    = (sel == 0) ? a_en    : b_en;
    assign m_txd   = (sel == 0) ? a_txd   : b_txd;
    assign m_busy  = (sel == 0) ? a_busy  : b_busy;
    assign m_done  = (sel == 0) ? a_done  : b_done;
    assign m_err   = (sel == 0) ? a_err   : b_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Monitor: captures every byte sent with tx_en high plus handshake/pulse statistics.
    logic [7:0] cap_q[$];
    int         gap_q[$];
    int         ready_cyc, done_cnt, err_cnt, busy_low, low_run;
    bit         seen_en, prev_en, track_busy;

    always @(negedge clk) begin
        if (m_en) begin
            cap_q.push_back(m_txd);
            if (!prev_en && seen_en) gap_q.push_back(low_run);
            seen_en = 1'b1;
            low_run = 0;
        end else begin
            low_run++;
        end
        if (m_ready) ready_cyc++;
        if (m_done)  done_cnt++;
        if (m_err)   err_cnt++;
        if (track_busy && seen_en && (done_cnt + err_cnt) < 2 && !m_busy) busy_low++;
        prev_en = m_en;
    end

    // Source queue, an unpopped copy for the model, and the expected GMII stream.
    logic [7:0] sq_data[$];
    bit         sq_last[$];
    logic [7:0] pay_all[$];
    logic [7:0] exp_q[$];
    int         acc;

    task automatic start_test(input int s);
        sel = s;
        cap_q.delete(); gap_q.delete(); exp_q.delete(); pay_all.delete();
        sq_data.delete(); sq_last.delete();
        ready_cyc = 0; done_cnt = 0; err_cnt = 0; busy_low = 0; low_run = 0;
        seen_en = 1'b0; prev_en = 1'b0; track_busy = 1'b0;
    endtask

    task automatic load_frame(input int len, input bit rnd, input logic [7:0] base);
        for (int i = 0; i < len; i++) begin
            logic [7:0] b;
            b = rnd ? 8'($urandom_range(0, 255)) : 8'(base + 8'(i));
            sq_data.push_back(b);
            sq_last.push_back(i == len - 1);
            pay_all.push_back(b);
        end
    endtask

    // Reference model: frame = preamble, SFD, body (payload + zero pad), FCS; CRC by bit-serial LFSR.
    task automatic expect_frame(input int first, input int n, input int min_len, input bit stomp);
        logic [7:0]  body[$];
        logic [31:0] crc;
        logic [31:0] fcs;
        for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        for (int i = 0; i < n; i++) body.push_back(pay_all[first + i]);
        if (!stomp) while (body.size() < min_len) body.push_back(8'h00);
        crc = 32'hFFFFFFFF;
        foreach (body[i]) begin
            for (int k = 0; k < 8; k++) begin
                bit fb;
                fb  = crc[0] ^ body[i][k];
                crc = crc >> 1;
                if (fb) crc = crc ^ 32'hEDB88320;
            end
        end
        fcs = stomp ? crc : ~crc;
        foreach (body[i]) exp_q.push_back(body[i]);
        for (int k = 0; k < 4; k++) exp_q.push_back(fcs[8*k +: 8]);
    endtask

    function automatic int first_diff();
        int n;
        n = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (cap_q[i] !== exp_q[i]) return i;
        if (cap_q.size() != exp_q.size()) return n;
        return -1;
    endfunction

    function automatic int got_at(input int i);
        return (i < cap_q.size()) ? int'(cap_q[i]) : -1;
    endfunction

    function automatic int exp_at(input int i);
        return (i < exp_q.size()) ? int'(exp_q[i]) : -1;
    endfunction

    task automatic present();
        if (sq_data.size() > 0) begin
            src_valid = 1'b1; src_data = sq_data[0]; src_last = sq_last[0];
        end else begin
            src_valid = 1'b0; src_data = 8'h00; src_last = 1'b0;
        end
    endtask

    // Source: keeps valid high while it has bytes; underrun_at/reset_at stop it after that many accepts.
    task automatic drive(input int underrun_at, input int reset_at, output bit timed_out);
        int budget;
        bit took;
        budget = 4000; timed_out = 1'b0; acc = 0;
        @(posedge clk); #1;
        present();
        while (src_valid) begin
            @(negedge clk);
            took = m_ready;
            @(posedge clk); #1;
            if (took) begin
                void'(sq_data.pop_front());
                void'(sq_last.pop_front());
                acc++;
                if (acc == underrun_at || acc == reset_at) begin
                    sq_data.delete(); sq_last.delete();
                end
            end
            budget--;
            if (budget == 0) begin
                timed_out = 1'b1; sq_data.delete(); sq_last.delete();
            end
            present();
        end
    endtask

    task automatic wait_end(input int n, output bit timed_out);
        int budget;
        budget = 3000;
        while ((done_cnt + err_cnt) < n && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        timed_out = ((done_cnt + err_cnt) < n);
        repeat (IFG_N + 4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({a_en, a_txd, a_ready, a_busy, a_done, a_err} !== 13'd0) begin
            n_fail++; $display("FAIL reset_hold_dut0 outputs got %h want 0", {a_en, a_txd, a_ready, a_busy, a_done, a_err});
        end
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({a_en, a_txd, a_ready, a_busy, a_done, a_err} !== 13'd0) begin
            n_fail++; $display("FAIL reset_dut0 outputs got %h want 0", {a_en, a_txd, a_ready, a_busy, a_done, a_err});
        end
        n_checks++;
        if ({b_en, b_txd, b_ready, b_busy, b_done, b_err} !== 13'd0) begin
            n_fail++; $display("FAIL reset_dut1 outputs got %h want 0", {b_en, b_txd, b_ready, b_busy, b_done, b_err});
        end
    endtask

    task automatic test_known_vector();
        bit to;
        int d;
        logic [7:0] fcs_bytes [4];
        fcs_bytes[0] = 8'h26; fcs_bytes[1] = 8'h39; fcs_bytes[2] = 8'hF4; fcs_bytes[3] = 8'hCB;
        start_test(0);
        load_frame(9, 1'b0, 8'h31);
        for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        for (int i = 0; i < 9; i++) exp_q.push_back(8'(8'h31 + 8'(i)));
        for (int i = 0; i < 4; i++) exp_q.push_back(fcs_bytes[i]);
        drive(0, 0, to);
        wait_end(1, to);
        n_checks++;
        if (to) begin n_fail++; $display("FAIL known_vector timeout waiting for frame end"); end
        d = first_diff();
        n_checks++;
        if (d >= 0) begin
            n_fail++; $display("FAIL known_vector byte %0d got %0h want %0h", d, got_at(d), exp_at(d));
        end
        n_checks++;
        if (cap_q.size() != 21) begin n_fail++; $display("FAIL known_vector tx_en cycles got %0d want 21", cap_q.size()); end
        n_checks++;
        if (done_cnt != 1 || err_cnt != 0) begin
            n_fail++; $display("FAIL known_vector done/err got %0d/%0d want 1/0", done_cnt, err_cnt);
        end
        n_checks++;
        if (ready_cyc != 9) begin n_fail++; $display("FAIL known_vector ready cycles got %0d want 9", ready_cyc); end
    endtask

    task automatic test_pad();
        bit to;
        int d;
        start_test(1);
        load_frame(10, 1'b0, 8'h01);
        expect_frame(0, 10, 60, 1'b0);
        drive(0, 0, to);
        wait_end(1, to);
        n_checks++;
        if (to) begin n_fail++; $display("FAIL pad timeout waiting for frame end"); end
        d = first_diff();
        n_checks++;
        if (d >= 0) begin n_fail++; $display("FAIL pad byte %0d got %0h want %0h", d, got_at(d), exp_at(d)); end
        n_checks++;
        if (cap_q.size() != 72) begin n_fail++; $display("FAIL pad tx_en cycles got %0d want 72", cap_q.size()); end
        n_checks++;
        if (got_at(67) != 0) begin n_fail++; $display("FAIL pad last pad byte got %0h want 0", got_at(67)); end
        n_checks++;
        if (ready_cyc != 10 || done_cnt != 1 || err_cnt != 0) begin
            n_fail++; $display("FAIL pad ready/done/err got %0d/%0d/%0d want 10/1/0", ready_cyc, done_cnt, err_cnt);
        end
    endtask

    task automatic test_long();
        bit to;
        int d;
        start_test(1);
        load_frame(100, 1'b1, 8'h00);
        expect_frame(0, 100, 60, 1'b0);
        drive(0, 0, to);
        wait_end(1, to);
        n_checks++;
        if (to) begin n_fail++; $display("FAIL long timeout waiting for frame end"); end
        d = first_diff();
        n_checks++;
        if (d >= 0) begin n_fail++; $display("FAIL long byte %0d got %0h want %0h", d, got_at(d), exp_at(d)); end
        n_checks++;
        if (cap_q.size() != 112 || ready_cyc != 100) begin
            n_fail++; $display("FAIL long tx_en/ready cycles got %0d/%0d want 112/100", cap_q.size(), ready_cyc);
        end
    endtask

    task automatic test_back_to_back();
        bit to;
        int d;
        start_test(1);
        load_frame(15, 1'b1, 8'h00);
        load_frame(70, 1'b1, 8'h00);
        expect_frame(0, 15, 60, 1'b0);
        expect_frame(15, 70, 60, 1'b0);
        track_busy = 1'b1;
        drive(0, 0, to);
        wait_end(2, to);
        n_checks++;
        if (to) begin n_fail++; $display("FAIL back_to_back timeout waiting for frame ends"); end
        d = first_diff();
        n_checks++;
        if (d >= 0) begin n_fail++; $display("FAIL back_to_back byte %0d got %0h want %0h", d, got_at(d), exp_at(d)); end
        n_checks++;
        if (gap_q.size() != 1) begin
            n_fail++; $display("FAIL back_to_back gap count got %0d want 1", gap_q.size());
        end else if (gap_q[0] != IFG_N) begin
            n_fail++; $display("FAIL back_to_back gap got %0d want %0d", gap_q[0], IFG_N);
        end
        n_checks++;
        if (busy_low != 0) begin n_fail++; $display("FAIL back_to_back busy low cycles got %0d want 0", busy_low); end
        n_checks++;
        if (done_cnt != 2 || err_cnt != 0 || ready_cyc != 85) begin
            n_fail++; $display("FAIL back_to_back done/err/ready got %0d/%0d/%0d want 2/0/85", done_cnt, err_cnt, ready_cyc);
        end
        track_busy = 1'b0;
    endtask

    task automatic test_underrun();
        bit to;
        int d;
        start_test(1);
        load_frame(30, 1'b1, 8'h00);
        expect_frame(0, 20, 60, 1'b1);
        drive(20, 0, to);
        wait_end(1, to);
        n_checks++;
        if (to) begin n_fail++; $display("FAIL underrun timeout waiting for frame end"); end
        d = first_diff();
        n_checks++;
        if (d >= 0) begin n_fail++; $display("FAIL underrun byte %0d got %0h want %0h", d, got_at(d), exp_at(d)); end
        n_checks++;
        if (cap_q.size() != 32) begin n_fail++; $display("FAIL underrun tx_en cycles got %0d want 32", cap_q.size()); end
        n_checks++;
        if (err_cnt != 1 || done_cnt != 0 || ready_cyc != 21) begin
            n_fail++; $display("FAIL underrun err/done/ready got %0d/%0d/%0d want 1/0/21", err_cnt, done_cnt, ready_cyc);
        end
    endtask

    task automatic test_reset_mid_frame();
        bit to;
        int d;
        start_test(1);
        load_frame(40, 1'b1, 8'h00);
        drive(0, 15, to);
        n_checks++;
        if (m_en !== 1'b1 || m_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_mid pre-reset en/ready got %b/%b want 1/1", m_en, m_ready);
        end
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({b_en, b_ready, b_busy, b_txd} !== 11'd0) begin
            n_fail++; $display("FAIL reset_mid async clear en/ready/busy/txd got %h want 0", {b_en, b_ready, b_busy, b_txd});
        end
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        start_test(1);
        load_frame(25, 1'b1, 8'h00);
        expect_frame(0, 25, 60, 1'b0);
        drive(0, 0, to);
        wait_end(1, to);
        d = first_diff();
        n_checks++;
        if (d >= 0) begin n_fail++; $display("FAIL reset_mid next frame byte %0d got %0h want %0h", d, got_at(d), exp_at(d)); end
        n_checks++;
        if (done_cnt != 1 || err_cnt != 0) begin
            n_fail++; $display("FAIL reset_mid next frame done/err got %0d/%0d want 1/0", done_cnt, err_cnt);
        end
    endtask

    task automatic test_random();
        bit to;
        int d, len, ur;
        for (int f = 0; f < 8; f++) begin
            start_test(f % 2);
            len = $urandom_range(1, 90);
            ur  = (len >= 2 && $urandom_range(0, 3) == 0) ? $urandom_range(1, len - 1) : 0;
            load_frame(len, 1'b1, 8'h00);
            expect_frame(0, (ur > 0) ? ur : len, (f % 2 == 0) ? 0 : 60, ur > 0);
            repeat ($urandom_range(0, 5)) @(posedge clk);
            drive(ur, 0, to);
            wait_end(1, to);
            d = first_diff();
            n_checks++;
            if (d >= 0) begin
                n_fail++; $display("FAIL random frame %0d len %0d ur %0d byte %0d got %0h want %0h", f, len, ur, d, got_at(d), exp_at(d));
            end
            n_checks++;
            if (done_cnt != ((ur > 0) ? 0 : 1) || err_cnt != ((ur > 0) ? 1 : 0)) begin
                n_fail++; $display("FAIL random frame %0d done/err got %0d/%0d underrun %0d", f, done_cnt, err_cnt, ur);
            end
        end
    endtask

    initial begin
        test_reset();
        test_known_vector();
        test_pad();
        test_long();
        test_back_to_back();
        test_underrun();
        test_reset_mid_frame();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/gmii_tx_mac.md
Name: gmii_tx_mac

Overview:
Transmit-side counterpart of the RGMII/GMII receive path. It takes a payload byte stream over a valid/ready handshake and frames it for GMII:
- 7-byte preamble, SFD, payload, zero padding to the minimum length, CRC-32 FCS, and the enforced inter-frame gap.
- Output drives gmii_tx_en/gmii_txd in the gmii_tx_clk domain, feeding the RGMII DDR output stage.

Parameters:
MIN_DATA_LEN, 60, minimum payload+pad bytes before FCS; 0 disables padding
IFG_CYCLES, 12, minimum idle cycles (tx_en low) between frames
PREAMBLE_LEN, 7, number of 0x55 preamble bytes before SFD

Ports:
gmii_tx_clk  in   1  GMII transmit clock (125 MHz); the single clock of the block
rst_n        in   1  asynchronous active-low reset
tx_data_valid in  1  source byte valid
tx_data      in   8  payload byte
tx_data_last in   1  qualifies final payload byte
tx_data_ready out 1  byte accepted when valid&ready
gmii_tx_en   out  1  GMII transmit enable
gmii_txd     out  8  GMII transmit data
tx_busy      out  1  frame or IFG in progress
tx_done      out  1  one-cycle pulse, frame completed normally
tx_err       out  1  one-cycle pulse, frame ended by underrun

Behaviour:
- One clock domain (gmii_tx_clk). Reset is asynchronous and active-low (rst_n).
- Reset values, all outputs 0: gmii_tx_en, gmii_txd, tx_data_ready, tx_busy, tx_done, tx_err. State = IDLE. CRC = 0xFFFFFFFF. Counters = 0.
- Reset mid-frame: outputs clear immediately and the frame is truncated with no FCS.
- gmii_tx_en/gmii_txd are registered. State encoding: IDLE, PREAMBLE, SFD, DATA, PAD, FCS, IFG.
- IDLE:
  - tx_data_ready=0.
  - If tx_data_valid=1 at an edge: gmii_tx_en<=1, gmii_txd<=0x55, tx_busy<=1, go to PREAMBLE.
  - One-cycle latency from valid to first preamble byte.
- PREAMBLE: emits PREAMBLE_LEN bytes of 0x55 total, then SFD 0xD5.
- DATA:
  - tx_data_ready is high during the cycle gmii_txd shows 0xD5 and every following DATA cycle.
  - Each accepted byte appears on gmii_txd at the next edge and updates the CRC.
  - The payload byte counter is 11 bits and saturates at 2047. No maximum length is enforced.
  - Accepted byte with tx_data_last=1: ready drops next cycle. Go to PAD if count < MIN_DATA_LEN, else FCS.
- Underrun: ready=1 and valid=0 in DATA.
  - Skip PAD and go to FCS with the complemented (stomped) FCS.
  - Pulse tx_err after the last FCS byte instead of tx_done.
- PAD: emits 0x00 (included in CRC) until payload+pad = MIN_DATA_LEN.
- FCS:
  - CRC-32 IEEE 802.3: reflected poly 0xEDB88320, init 0xFFFFFFFF, computed over payload+pad only.
  - FCS = ~crc, sent LSB byte first, 4 bytes.
- IFG:
  - gmii_tx_en<=0, gmii_txd<=0x00 for exactly IFG_CYCLES cycles.
  - tx_done (or tx_err) pulses in the first IFG cycle.
  - tx_busy drops when returning to IDLE.
  - tx_data_valid is ignored until IDLE; the source holds its data meanwhile.
- 1-byte frame (valid and last on the first byte) is legal.
- Back-to-back frames: next preamble starts the cycle after IFG ends, so the gap is exactly IFG_CYCLES.

Decomposition:
- Package eth_tx_pkg holds:
  - state enum;
  - PREAMBLE_BYTE 0x55, SFD_BYTE 0xD5, CRC_POLY_REFL 0xEDB88320, CRC_INIT 0xFFFFFFFF;
  - function crc32_next_d8(crc, byte).
- Sub-module crc32_d8: 32-bit register with init (sync clear) and enable, plus the byte-wide next-state function.

Test Plan:
- MIN_DATA_LEN=0, payload "123456789":
  - gmii_txd = 55×7, D5, 31..39, 26 39 F4 CB.
  - tx_en high 21 cycles; tx_done one pulse; tx_err 0.
- Default params, 10-byte payload 0x01..0x0A:
  - 50 bytes 0x00 pad; tx_en high 8+60+4=72 cycles.
  - FCS equals zlib crc32 of the 60 bytes, LSB first.
- 100-byte payload:
  - tx_data_ready high exactly 100 cycles, no pad, tx_en 112 cycles.
- Two back-to-back frames with valid held high:
  - tx_en low exactly 12 cycles between them; tx_busy stays 1 throughout.
- Underrun, valid dropped after byte 20 (default params):
  - no pad; FCS = bitwise complement of the correct CRC; tx_en 32 cycles.
  - tx_err pulse, tx_done 0.
- rst_n low mid-DATA:
  - gmii_tx_en/ready/busy go 0 asynchronously.
  - After release, the next frame is bit-exact against the model.
